// File: rtl/stall_sequencer_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall sequencer.
// master = pipeline side (drives hazard inputs), slave = sequencer (drives stall controls).
interface stall_sequencer_if;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       id_branch;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       pipe_hold;
    logic       mem_tmo;
    logic [1:0] state;

    modport master (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2, id_branch, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_tmo, state
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, id_branch, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_tmo, state
    );
endinterface

// File: rtl/stall_sequencer.sv
// Pipeline stall sequencer: memory freeze, load-use bubble and branch fetch suppression.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module stall_sequencer #(
    parameter int BR_WAIT = 2,
    parameter int TMO_CYC = 255,
    parameter int PERF_W  = 32
) (
    input  logic clk,
    input  logic rst_n,
`ifdef STALL_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [PERF_W-1:0] cnt_loaduse,
    output logic [PERF_W-1:0] cnt_branch,
    output logic [PERF_W-1:0] cnt_freeze,
`endif
    stall_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_BRW    = 2'b01,
        ST_FREEZE = 2'b10
    } state_t;

    // Branch acceptance itself is one suppressed cycle, hence the -2 preload.
    localparam logic [3:0] CNT_LOAD = (BR_WAIT >= 2) ? 4'(BR_WAIT - 2) : 4'd0;
    localparam logic [7:0] TMO_LIM  = 8'(TMO_CYC);

    if (BR_WAIT < 1 || BR_WAIT > 15) begin : g_bad_br_wait
        $error("BR_WAIT must be in 1..15");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("PERF_W must be at least 1");
    end

    state_t     state_reg, state_next, state_view;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] fcnt_reg, fcnt_next;
    logic       tmo_reg, tmo_next;

    logic freeze;
    logic load_use;
    logic lu_stall;
    logic br_accept;

    logic pc_w, ifid_w, ifid_f, hold;

    assign freeze   = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                      ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));

    assign lu_stall  = ~freeze && (state_reg == ST_RUN) && load_use;
    assign br_accept = ~freeze && (state_reg == ST_RUN) && ~load_use && bus.id_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 4'd0;
            fcnt_reg  <= 8'd0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fcnt_reg  <= fcnt_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        state_view = state_reg;
        pc_w       = 1'b0;
        ifid_w     = 1'b0;
        ifid_f     = 1'b0;
        hold       = 1'b0;

        if (freeze) begin
            // Everything holds, including the branch countdown.
            hold       = 1'b1;
            state_view = ST_FREEZE;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (lu_stall) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                    end else if (br_accept) begin
                        ifid_f = 1'b1;
                        ifid_w = 1'b1;
                        if (BR_WAIT <= 1) begin
                            pc_w = 1'b1;
                        end else begin
                            state_next = ST_BRW;
                            cnt_next   = CNT_LOAD;
                        end
                    end else begin
                        pc_w   = 1'b1;
                        ifid_w = 1'b1;
                    end
                end
                ST_BRW: begin
                    ifid_f = 1'b1;
                    ifid_w = 1'b1;
                    if (cnt_reg != 4'd0) begin
                        cnt_next = cnt_reg - 4'd1;
                    end else begin
                        pc_w       = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    // Freeze-length watchdog: saturating run length, cleared by any non-freeze cycle.
    always_comb begin
        fcnt_next = 8'd0;
        tmo_next  = tmo_reg;
        if (freeze) begin
            fcnt_next = (fcnt_reg == 8'hFF) ? 8'hFF : fcnt_reg + 8'd1;
            if (fcnt_next == TMO_LIM) begin
                tmo_next = 1'b1;
            end
        end
    end

    // While reset is asserted every control output reads 0.
    assign bus.pc_write   = rst_n & pc_w;
    assign bus.ifid_write = rst_n & ifid_w;
    assign bus.ifid_flush = rst_n & ifid_f;
    assign bus.idex_flush = rst_n & lu_stall;
    assign bus.pipe_hold  = rst_n & hold;
    assign bus.state      = rst_n ? state_view : 2'b00;
    assign bus.mem_tmo    = tmo_reg;

`ifdef STALL_PERF_CNT_EN
    logic [2:0] perf_inc;
    assign perf_inc = {freeze, br_accept, lu_stall};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [PERF_W-1:0] val_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_reg <= '0;
            end else if (perf_clr) begin
                val_reg <= '0;
            end else if (perf_inc[gi] && (val_reg != '1)) begin
                val_reg <= val_reg + 1'b1;
            end
        end
    end

    assign cnt_loaduse = g_perf[0].val_reg;
    assign cnt_branch  = g_perf[1].val_reg;
    assign cnt_freeze  = g_perf[2].val_reg;
`endif

endmodule
